gf180mcu_osu_sc_9t_dff_pipe: RTL and testbench

//  Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit flops with valid/ready flow control.

---
 rtl/gf180mcu_osu_sc_9t_dff_pipe_if.sv | 29 ++
 rtl/gf180mcu_osu_sc_9t_dff_pipe.sv | 78 +++++++
 tb/tb_gf180mcu_osu_sc_9t_dff_pipe.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_osu_sc_9t_dff_pipe_if.sv
// Handshake bundle for the elastic pipeline register: upstream push side,
// downstream pop side and the occupancy count.
interface gf180mcu_osu_sc_9t_dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  // A word moves across a side only on a clock edge where its valid and ready
  // are both high; valid must not depend on ready, and ready may depend on
  // valid only through registered state.
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] d;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [CNT_W-1:0] cnt;

  modport master (
    output in_vld, d, out_rdy,
    input  in_rdy, out_vld, q, qn, cnt
  );

  modport slave (
    input  in_vld, d, out_rdy,
    output in_rdy, out_vld, q, qn, cnt
  );
endinterface

// File: rtl/gf180mcu_osu_sc_9t_dff_pipe.sv
// Elastic pipeline register: DEPTH stages of WIDTH-bit flops with valid/ready
// backpressure, bubble collapse, Q/QN outputs and an occupancy count.
module gf180mcu_osu_sc_9t_dff_pipe #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input logic                        clk,
  input logic                        rst,
  gf180mcu_osu_sc_9t_dff_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] rdy;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             in_xfer;
  logic             out_xfer;

  // Ready ripples from the output back towards the input through a scalar so
  // the rdy vector is never read inside the block that writes it.
  always_comb begin
    logic r;
    rdy = '0;
    r   = bus.out_rdy;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = ~vld_q[i] | r;
      rdy[i] = r;
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (rdy[0]) begin
      data_d[0] = bus.d;
      vld_d[0]  = bus.in_vld;
    end
    // Bubbles are copied too; their data is never qualified by a valid bit.
    for (int i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
    in_xfer  = bus.in_vld & rdy[0];
    out_xfer = vld_q[DEPTH-1] & bus.out_rdy;
    cnt_d    = cnt_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.in_rdy  = rdy[0];
  assign bus.out_vld = vld_q[DEPTH-1];
  assign bus.q       = data_q[DEPTH-1];
  assign bus.qn      = ~data_q[DEPTH-1];
  assign bus.cnt     = cnt_q;
endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_dff_pipe.sv
// Directed bench for the elastic pipeline register at DEPTH 3, 4 and 1.
module tb_gf180mcu_osu_sc_9t_dff_pipe;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [7:0] exp_q[$];

  gf180mcu_osu_sc_9t_dff_pipe_if #(.WIDTH(8), .DEPTH(3)) if3 ();
  gf180mcu_osu_sc_9t_dff_pipe_if #(.WIDTH(8), .DEPTH(4)) if4 ();
  gf180mcu_osu_sc_9t_dff_pipe_if #(.WIDTH(8), .DEPTH(1)) if1 ();

  gf180mcu_osu_sc_9t_dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u_d3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );
  gf180mcu_osu_sc_9t_dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_d4 (
    .clk(clk), .rst(rst), .bus(if4.slave)
  );
  gf180mcu_osu_sc_9t_dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_d1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    if3.in_vld = 1'b0; if3.d = 8'h00; if3.out_rdy = 1'b0;
    if4.in_vld = 1'b0; if4.d = 8'h00; if4.out_rdy = 1'b0;
    if1.in_vld = 1'b0; if1.d = 8'h00; if1.out_rdy = 1'b0;
  endtask

  initial begin
    int n_pop;
    total = 0;
    bad   = 0;
    idle_all();

    // reset, held for two cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_q",      if3.q,       8'hA5);
    chk("rst_qn",     if3.qn,      8'h5A);
    chk("rst_vld",    if3.out_vld, 0);
    chk("rst_cnt",    if3.cnt,     0);
    chk("rst_in_rdy", if3.in_rdy,  1);
    chk("rst_d4_cnt", if4.cnt,     0);

    // streaming 01..10 through DEPTH=3 with the output always ready
    if3.out_rdy = 1'b1;
    n_pop = 0;
    for (int cyc = 0; cyc < 19; cyc++) begin
      if3.in_vld = (cyc < 16);
      if3.d      = 8'(cyc + 1);
      #1;
      chk("stream_in_rdy", if3.in_rdy, 1);
      if (cyc == 3) begin
        chk("stream_lat_vld", if3.out_vld, 1);
        chk("stream_lat_q",   if3.q,       8'h01);
      end
      if (cyc >= 3 && cyc <= 16) chk("stream_cnt", if3.cnt, 3);
      if (if3.out_vld && if3.out_rdy) begin
        if (exp_q.size() == 0) chk("stream_extra", 1, 0);
        else chk("stream_q", if3.q, exp_q.pop_front());
        n_pop++;
      end
      if (if3.in_vld && if3.in_rdy) exp_q.push_back(if3.d);
      tick();
    end
    chk("stream_npop",  n_pop,        16);
    chk("stream_left",  exp_q.size(), 0);
    chk("stream_cnt0",  if3.cnt,      0);
    chk("stream_vld0",  if3.out_vld,  0);

    // stall and fill with 11,22,33
    if3.out_rdy = 1'b0;
    if3.in_vld  = 1'b1;
    if3.d = 8'h11; tick();
    if3.d = 8'h22; tick();
    if3.d = 8'h33; tick();
    if3.d = 8'h44;
    #1;
    chk("full_cnt",    if3.cnt,     3);
    chk("full_in_rdy", if3.in_rdy,  0);
    chk("full_q",      if3.q,       8'h11);
    chk("full_vld",    if3.out_vld, 1);
    tick();
    chk("full_hold_cnt", if3.cnt, 3);
    chk("full_hold_q",   if3.q,   8'h11);
    chk("full_hold_qn",  if3.qn,  8'hEE);

    // push and pop together while full
    if3.out_rdy = 1'b1;
    #1;
    chk("pp_in_rdy", if3.in_rdy, 1);
    tick();
    if3.in_vld = 1'b0;
    chk("pp_cnt", if3.cnt, 3);
    chk("pp_q0",  if3.q,   8'h22);
    tick();
    chk("pp_q1",  if3.q,   8'h33);
    tick();
    chk("pp_q2",  if3.q,   8'h44);
    chk("pp_vld", if3.out_vld, 1);
    tick();
    chk("pp_empty_vld", if3.out_vld, 0);
    chk("pp_empty_cnt", if3.cnt,     0);
    chk("pp_empty_rdy", if3.in_rdy,  1);
    if3.out_rdy = 1'b0;

    // bubble collapse in DEPTH=4: AA, idle, BB with the output stalled
    if4.out_rdy = 1'b0;
    if4.in_vld = 1'b1; if4.d = 8'hAA; tick();
    if4.in_vld = 1'b0; tick();
    if4.in_vld = 1'b1; if4.d = 8'hBB; tick();
    if4.in_vld = 1'b0;
    tick();
    tick();
    tick();
    chk("bub_cnt",    if4.cnt,     2);
    chk("bub_in_rdy", if4.in_rdy,  1);
    chk("bub_vld",    if4.out_vld, 1);
    chk("bub_q",      if4.q,       8'hAA);

    // reset mid-stream; a word offered during reset is dropped
    rst = 1'b1;
    if4.in_vld = 1'b1; if4.d = 8'hCC;
    #1;
    chk("mrst_in_rdy", if4.in_rdy, 1);
    tick();
    rst = 1'b0;
    if4.in_vld = 1'b0;
    if4.out_rdy = 1'b1;
    chk("mrst_cnt", if4.cnt,     0);
    chk("mrst_vld", if4.out_vld, 0);
    chk("mrst_q",   if4.q,       8'hA5);
    chk("mrst_qn",  if4.qn,      8'h5A);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mrst_no_out", if4.out_vld, 0);
    end

    // single-stage pipe: stall, then push and pop in the same cycle
    if1.out_rdy = 1'b0;
    if1.in_vld = 1'b1; if1.d = 8'h5A;
    tick();
    if1.d = 8'h3C;
    #1;
    chk("d1_vld",    if1.out_vld, 1);
    chk("d1_q",      if1.q,       8'h5A);
    chk("d1_cnt",    if1.cnt,     1);
    chk("d1_stall",  if1.in_rdy,  0);
    if1.out_rdy = 1'b1;
    #1;
    chk("d1_pp_rdy", if1.in_rdy,  1);
    tick();
    chk("d1_pp_q",   if1.q,       8'h3C);
    chk("d1_pp_cnt", if1.cnt,     1);
    if1.in_vld = 1'b0;
    tick();
    chk("d1_empty_vld", if1.out_vld, 0);
    chk("d1_empty_cnt", if1.cnt,     0);

    idle_all();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
